// File: rtl/csr_pkg.sv
// ============================================================================
//  Module : csr_pkg
//  Brief  : Shared constants for the sharpening CSR block: register map,
//           STATUS bit positions and the access FSM state encoding.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package csr_pkg;

  // Register addresses
  localparam logic [2:0] ADDR_ID       = 3'd0;
  localparam logic [2:0] ADDR_CTRL     = 3'd1;
  localparam logic [2:0] ADDR_STATUS   = 3'd2;
  localparam logic [2:0] ADDR_IMG_BASE = 3'd3;
  localparam logic [2:0] ADDR_DIM      = 3'd4;

  // CTRL / STATUS bit positions
  localparam int CTRL_START_BIT  = 0;
  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_DONE_BIT = 1;

  // Requester index inside the arbiter request/grant vectors
  localparam int REQ_CPU = 0;
  localparam int REQ_DBG = 1;

  // Access FSM
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
//  Module : rr_arb2
//  Brief  : Two-way arbiter, one-hot grant. Bit 0 = CPU, bit 1 = debug host.
//           Default build: round-robin with a last-grant pointer that resets
//           to the debug side, so the CPU wins the first tie.
//           With DBG_PRIORITY_EN defined: debug always wins, no pointer.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arb2
  import csr_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       take,   // grant is being consumed this cycle
  output logic [1:0] grant
);

`ifdef DBG_PRIORITY_EN
  // Clock, reset and take are not needed without a pointer
  logic unused_ok;
  assign unused_ok = ^{clk, rst_n, take};

  // Fixed priority: debug host first
  always_comb begin
    grant = 2'b00;
    if (req[REQ_DBG])      grant[REQ_DBG] = 1'b1;
    else if (req[REQ_CPU]) grant[REQ_CPU] = 1'b1;
  end
`else
  logic last_dbg;

  // Round-robin: on a tie the side not granted last wins
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_dbg ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Remember who was granted last, updated only when a grant is taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    last_dbg <= 1'b1;
    else if (take) last_dbg <= grant[REQ_DBG];
  end
`endif

endmodule

`default_nettype wire

// File: rtl/csr_arbiter.sv
// ============================================================================
//  Module : csr_arbiter
//  Brief  : Control/status register block for the image-sharpening engine.
//           Shares one register port between the CPU and the debug host,
//           holds ID / CTRL / STATUS / IMG_BASE / DIM, drives cfg_* outputs.
//           Optional macro DBG_PRIORITY_EN: debug host wins every tie.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module csr_arbiter
  import csr_pkg::*;
#(
  parameter logic [7:0] ID_VALUE = 8'hA5,
  parameter int         DW       = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [2:0]    cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [2:0]    dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_ack,
  output logic [DW-1:0] dbg_rdata,
  input  logic          sharp_busy,
  input  logic          sharp_done,
  output logic          cfg_start,
  output logic [31:0]   cfg_img_base,
  output logic [15:0]   cfg_width,
  output logic [15:0]   cfg_height
);

  state_t        state;
  logic          owner_dbg;
  logic          lat_we;
  logic [2:0]    lat_addr;
  logic [DW-1:0] lat_wdata;
  logic [31:0]   wdata32;
  logic [31:0]   img_base;
  logic [31:0]   dim;
  logic          done;
  logic [31:0]   rd_val;
  logic [1:0]    grant;
  logic          take;
  logic          clr_done;

  assign take    = (state == IDLE) && (cpu_req || dbg_req);
  assign wdata32 = 32'(lat_wdata);

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({dbg_req, cpu_req}),
    .take  (take),
    .grant (grant)
  );

  assign cfg_img_base = img_base;
  assign cfg_width    = dim[15:0];
  assign cfg_height   = dim[31:16];

  assign clr_done = (state == ACCESS) && lat_we && (lat_addr == ADDR_STATUS)
                    && wdata32[STATUS_DONE_BIT];

  // Read mux for the latched address
  always_comb begin
    rd_val = 32'h0;
    case (lat_addr)
      ADDR_ID:       rd_val = {24'h0, ID_VALUE};
      ADDR_STATUS: begin
        rd_val[STATUS_BUSY_BIT] = sharp_busy;
        rd_val[STATUS_DONE_BIT] = done;
      end
      ADDR_IMG_BASE: rd_val = img_base;
      ADDR_DIM:      rd_val = dim;
      default:       rd_val = 32'h0;
    endcase
  end

  // Access FSM with registered acks, read data, start pulse and config regs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner_dbg <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= 3'd0;
      lat_wdata <= '0;
      img_base  <= 32'h0;
      dim       <= 32'h0;
      cpu_ack   <= 1'b0;
      dbg_ack   <= 1'b0;
      cpu_rdata <= '0;
      dbg_rdata <= '0;
      cfg_start <= 1'b0;
    end else begin
      cpu_ack   <= 1'b0;
      dbg_ack   <= 1'b0;
      cpu_rdata <= '0;
      dbg_rdata <= '0;
      cfg_start <= 1'b0;
      case (state)
        IDLE: begin
          if (take) begin
            owner_dbg <= grant[REQ_DBG];
            lat_we    <= grant[REQ_DBG] ? dbg_we    : cpu_we;
            lat_addr  <= grant[REQ_DBG] ? dbg_addr  : cpu_addr;
            lat_wdata <= grant[REQ_DBG] ? dbg_wdata : cpu_wdata;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (lat_we) begin
            case (lat_addr)
              ADDR_CTRL:     cfg_start <= wdata32[CTRL_START_BIT] && !sharp_busy;
              ADDR_IMG_BASE: img_base  <= wdata32;
              ADDR_DIM:      dim       <= wdata32;
              default:       ;
            endcase
          end
          // Writes return zero data; reads return the selected register
          if (owner_dbg) begin
            dbg_ack   <= 1'b1;
            dbg_rdata <= lat_we ? '0 : DW'(rd_val);
          end else begin
            cpu_ack   <= 1'b1;
            cpu_rdata <= lat_we ? '0 : DW'(rd_val);
          end
          state <= ACK;
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky done flag: engine completion wins over a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          done <= 1'b0;
    else if (sharp_done) done <= 1'b1;
    else if (clr_done)   done <= 1'b0;
  end

endmodule

`default_nettype wire

// File: tb/tb_csr_arbiter.sv
// ============================================================================
//  Module : tb_csr_arbiter
//  Brief  : Self-checking bench for csr_arbiter with a register-map model.
//           Honours DBG_PRIORITY_EN for tie expectations.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_csr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 0, cpu_we = 0, dbg_req = 0, dbg_we = 0;
  logic [2:0]  cpu_addr = 0, dbg_addr = 0;
  logic [31:0] cpu_wdata = 0, dbg_wdata = 0;
  logic        cpu_ack, dbg_ack;
  logic [31:0] cpu_rdata, dbg_rdata;
  logic        sharp_busy = 0, sharp_done = 0;
  logic        cfg_start;
  logic [31:0] cfg_img_base;
  logic [15:0] cfg_width, cfg_height;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] m_img, m_dim;
  logic        m_done;
  logic        m_last_dbg;

  always #5 clk = ~clk;

  csr_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .sharp_busy(sharp_busy), .sharp_done(sharp_done),
    .cfg_start(cfg_start), .cfg_img_base(cfg_img_base),
    .cfg_width(cfg_width), .cfg_height(cfg_height)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0:    return 32'h0000_00A5;
      3'd2:    return {30'h0, m_done, sharp_busy};
      3'd3:    return m_img;
      3'd4:    return m_dim;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_img = 0; m_dim = 0; m_done = 0; m_last_dbg = 1'b1;
  endtask

  // Protocol invariants checked every cycle
  always @(negedge clk) begin
    if (!cpu_ack) chk("cpu_rdata_when_idle", cpu_rdata, 32'h0);
    if (!dbg_ack) chk("dbg_rdata_when_idle", dbg_rdata, 32'h0);
    chk("both_acks", {31'h0, cpu_ack & dbg_ack}, 32'h0);
  end

  // Single-requester transaction; collide pulses sharp_done at the write edge
  task automatic txn(input bit dbg, input bit we, input logic [2:0] a,
                     input logic [31:0] wd, input bit collide, input string tag);
    logic [31:0] exp_rd;
    logic        exp_start;
    exp_rd    = we ? 32'h0 : model_read(a);
    exp_start = we && (a == 3'd1) && wd[0] && !sharp_busy;
    if (dbg) begin dbg_req = 1; dbg_we = we; dbg_addr = a; dbg_wdata = wd; end
    else     begin cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = wd; end
    @(negedge clk);
    chk({tag, "_early"}, {30'h0, dbg_ack, cpu_ack}, 32'h0);
    if (collide) sharp_done = 1;
    @(negedge clk);
    if (collide) sharp_done = 0;
    chk({tag, "_ack"}, {30'h0, dbg_ack, cpu_ack}, dbg ? 32'h2 : 32'h1);
    if (!we) chk({tag, "_rdata"}, dbg ? dbg_rdata : cpu_rdata, exp_rd);
    chk({tag, "_start"}, {31'h0, cfg_start}, {31'h0, exp_start});
    cpu_req = 0; dbg_req = 0;
    m_last_dbg = dbg;
    if (we) begin
      if (a == 3'd3) m_img = wd;
      if (a == 3'd4) m_dim = wd;
      if (a == 3'd2 && wd[1]) m_done = 0;
    end
    if (collide) m_done = 1;
    @(negedge clk);
    chk({tag, "_ack_end"}, {30'h0, dbg_ack, cpu_ack}, 32'h0);
    chk({tag, "_start_end"}, {31'h0, cfg_start}, 32'h0);
    chk({tag, "_img"}, cfg_img_base, m_img);
    chk({tag, "_dim"}, {cfg_height, cfg_width}, m_dim);
  endtask

  // Both requesters rise together and hold until served
  task automatic tie(input string tag);
    bit          win_dbg;
    logic [31:0] exp_c, exp_d;
`ifdef DBG_PRIORITY_EN
    win_dbg = 1'b1;
`else
    win_dbg = !m_last_dbg;
`endif
    exp_c = model_read(3'd0);
    exp_d = model_read(3'd3);
    cpu_req = 1; cpu_we = 0; cpu_addr = 3'd0;
    dbg_req = 1; dbg_we = 0; dbg_addr = 3'd3;
    @(negedge clk);
    chk({tag, "_early"}, {30'h0, dbg_ack, cpu_ack}, 32'h0);
    @(negedge clk);
    chk({tag, "_first"}, {30'h0, dbg_ack, cpu_ack}, win_dbg ? 32'h2 : 32'h1);
    chk({tag, "_first_rd"}, win_dbg ? dbg_rdata : cpu_rdata, win_dbg ? exp_d : exp_c);
    if (win_dbg) dbg_req = 0; else cpu_req = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk({tag, "_gap"}, {30'h0, dbg_ack, cpu_ack}, 32'h0);
    end
    @(negedge clk);
    chk({tag, "_second"}, {30'h0, dbg_ack, cpu_ack}, win_dbg ? 32'h1 : 32'h2);
    chk({tag, "_second_rd"}, win_dbg ? cpu_rdata : dbg_rdata, win_dbg ? exp_c : exp_d);
    cpu_req = 0; dbg_req = 0;
    m_last_dbg = !win_dbg;
    @(negedge clk);
    chk({tag, "_end"}, {30'h0, dbg_ack, cpu_ack}, 32'h0);
  endtask

  task automatic done_pulse();
    sharp_done = 1;
    @(negedge clk);
    sharp_done = 0;
    m_done = 1;
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_acks", {30'h0, dbg_ack, cpu_ack}, 32'h0);
    chk("rst_start", {31'h0, cfg_start}, 32'h0);
    chk("rst_img", cfg_img_base, 32'h0);
    chk("rst_dim", {cfg_height, cfg_width}, 32'h0);
    rst_n = 1;
    @(negedge clk);

    // First tie after reset, then the basic accesses
    tie("tie_first");
    txn(0, 0, 3'd0, 32'h0, 0, "cpu_read_id");
    txn(1, 1, 3'd3, 32'h1000_0000, 0, "dbg_wr_img");
    txn(0, 0, 3'd3, 32'h0, 0, "cpu_rd_img");
    tie("tie_second");
    txn(1, 1, 3'd0, 32'hFFFF_FFFF, 0, "wr_id_ignored");
    txn(0, 0, 3'd0, 32'h0, 0, "rd_id_again");
    txn(0, 1, 3'd6, 32'h1234_5678, 0, "wr_unmapped");
    txn(1, 0, 3'd6, 32'h0, 0, "rd_unmapped");

    // Start pulse gated by busy
    sharp_busy = 0;
    txn(0, 1, 3'd1, 32'h1, 0, "start_idle");
    sharp_busy = 1;
    txn(0, 1, 3'd1, 32'h1, 0, "start_busy");
    txn(1, 0, 3'd2, 32'h0, 0, "status_busy");
    sharp_busy = 0;
    txn(0, 0, 3'd1, 32'h0, 0, "ctrl_reads_zero");

    // Done flag: set, clear collision, clear
    done_pulse();
    txn(0, 0, 3'd2, 32'h0, 0, "status_done");
    txn(1, 1, 3'd2, 32'h2, 1, "clr_collide");
    txn(0, 0, 3'd2, 32'h0, 0, "status_after_collide");
    txn(1, 1, 3'd2, 32'h2, 0, "clr_done");
    txn(0, 0, 3'd2, 32'h0, 0, "status_cleared");

    // Randomized traffic against the model
    for (int n = 0; n < 60; n++) begin
      sharp_busy = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) done_pulse();
      if ($urandom_range(0, 7) == 0) tie("tie_rand");
      else txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               3'($urandom_range(0, 7)), $urandom, 0, "rand");
    end
    sharp_busy = 0;

    // Reset during ACCESS of a DIM write
    txn(1, 1, 3'd3, 32'hCAFE_0000, 0, "pre_rst_img");
    cpu_req = 1; cpu_we = 1; cpu_addr = 3'd4; cpu_wdata = 32'h0040_0080;
    @(negedge clk);
    rst_n = 0;
    cpu_req = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_mid_no_ack", {30'h0, dbg_ack, cpu_ack}, 32'h0);
    end
    rst_n = 1;
    model_reset();
    @(negedge clk);
    chk("rst_mid_ack", {30'h0, dbg_ack, cpu_ack}, 32'h0);
    chk("rst_mid_width", {16'h0, cfg_width}, 32'h0);
    chk("rst_mid_height", {16'h0, cfg_height}, 32'h0);
    chk("rst_mid_img", cfg_img_base, 32'h0);
    txn(1, 0, 3'd4, 32'h0, 0, "rd_dim_after_rst");
    tie("tie_after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
